// File: rtl/nco_mixer.sv
// nco_mixer: down-conversion mixer that sits behind the NCO.
// Each ADC sample is delayed by NCO_LAT ce-cycles so that it lines up with the
// LO value generated for it. The sample is multiplied by the signed LO, then
// rounded half-up back to OUT_W bits with saturation. A sticky, clearable
// counter records how many saturated outputs have been produced.
module nco_mixer #(
  parameter int DATA_W      = 16,
  parameter int PHASE_W     = 18,
  parameter int PHASE_POINT = 16,
  parameter int OUT_W       = 16,
  parameter int NCO_LAT     = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  input  logic [DATA_W-1:0]  i_sample,
  input  logic               i_valid,
  input  logic [PHASE_W-1:0] i_lo,
  input  logic               i_clr_sat,
  output logic [OUT_W-1:0]   o_mix,
  output logic               o_valid,
  output logic               o_sat,
  output logic [CNT_W-1:0]   o_sat_cnt
);

  localparam int PROD_W = DATA_W + PHASE_W;
  // One guard bit keeps the rounding add from wrapping.
  localparam int SUM_W  = PROD_W + 1;
  localparam int R_W    = SUM_W - PHASE_POINT;
  // Valid stage layout:
  //   [1..NCO_LAT] = delay line
  //   [NCO_LAT+1]  = M1 (product)
  //   [NCO_LAT+2]  = M2 (output)
  localparam int STAGES = NCO_LAT + 2;

  localparam logic [SUM_W-1:0]      HALF  = SUM_W'(1) << (PHASE_POINT - 1);
  localparam logic signed [R_W-1:0] MAX_R = {{(R_W-OUT_W){1'b0}}, 1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [R_W-1:0] MIN_R = {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]      MAX_O = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      MIN_O = {1'b1, {(OUT_W-1){1'b0}}};

  // State
  logic [STAGES:1]                 vld_pipe_q, vld_pipe_d;
  logic [NCO_LAT:1][DATA_W-1:0]    dly_q, dly_d;
  logic signed [PROD_W-1:0]        prod_q, prod_d;
  logic [OUT_W-1:0]                mix_q, mix_d;
  logic                            sat_q, sat_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  // Combinational datapath
  logic [SUM_W-1:0]                sum;
  logic signed [R_W-1:0]           r;
  logic                            sat_hi, sat_lo, sat_evt;
  logic [PHASE_POINT-1:0]          unused_sum_lo;
  logic                            unused_ok;

  // Delay line and valid shift register advance together on every enabled edge.
  always_comb begin
    dly_d      = dly_q;
    vld_pipe_d = vld_pipe_q;
    if (ce) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], i_valid};
      dly_d[1]   = i_sample;
      for (int i = 2; i <= NCO_LAT; i++) dly_d[i] = dly_q[i-1];
    end
  end

  // M1: full-width signed product of the aligned sample and the current LO.
  always_comb begin
    prod_d = prod_q;
    if (ce)
      prod_d = PROD_W'($signed(dly_q[NCO_LAT])) * PROD_W'($signed(i_lo));
  end

  // Round half-up: add half an LSB, then drop the fraction bits.
  // Dropping bits from the sign-extended sum is an arithmetic shift.
  always_comb begin
    sum           = {prod_q[PROD_W-1], prod_q} + HALF;
    r             = $signed(sum[SUM_W-1:PHASE_POINT]);
    unused_sum_lo = sum[PHASE_POINT-1:0];
    sat_hi        = (r > MAX_R);
    sat_lo        = (r < MIN_R);
    sat_evt       = vld_pipe_q[STAGES-1] & (sat_hi | sat_lo);
  end

  assign unused_ok = &{1'b0, unused_sum_lo};

  // M2: clamp into OUT_W. o_mix only moves on valid data; o_sat is a per-sample pulse.
  always_comb begin
    mix_d = mix_q;
    sat_d = sat_q;
    if (ce) begin
      sat_d = 1'b0;
      if (vld_pipe_q[STAGES-1]) begin
        if (sat_hi)      mix_d = MAX_O;
        else if (sat_lo) mix_d = MIN_O;
        else             mix_d = r[OUT_W-1:0];
        sat_d = sat_hi | sat_lo;
      end
    end
  end

  // Saturation counter: it sticks at all-ones, and a clear overrides an event on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (ce) begin
      if (i_clr_sat)                      cnt_d = '0;
      else if (sat_evt && (cnt_q != '1))  cnt_d = cnt_q + 1'b1;
    end
  end

  // All state registers: asynchronous clear, load the next-state values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      dly_q      <= '0;
      prod_q     <= '0;
      mix_q      <= '0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dly_q      <= dly_d;
      prod_q     <= prod_d;
      mix_q      <= mix_d;
      sat_q      <= sat_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_mix     = mix_q;
  assign o_valid   = vld_pipe_q[STAGES];
  assign o_sat     = sat_q;
  assign o_sat_cnt = cnt_q;

endmodule

// File: tb/tb_nco_mixer.sv
// Directed bench for nco_mixer. It uses a default-parameter instance and a
// second instance with CNT_W=4. Both instances share the same stimulus; the
// second one shows the counter sticking at its maximum.
module tb_nco_mixer;

  logic        clk = 1'b0;
  logic        reset_n, ce, i_valid, i_clr_sat;
  logic [15:0] i_sample;
  logic [17:0] i_lo;
  logic [15:0] o_mix, o_mix4, o_sat_cnt;
  logic        o_valid, o_sat, o_valid4, o_sat4;
  logic [3:0]  o_sat_cnt4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nco_mixer dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .i_sample(i_sample), .i_valid(i_valid),
    .i_lo(i_lo), .i_clr_sat(i_clr_sat), .o_mix(o_mix), .o_valid(o_valid),
    .o_sat(o_sat), .o_sat_cnt(o_sat_cnt)
  );

  nco_mixer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .i_sample(i_sample), .i_valid(i_valid),
    .i_lo(i_lo), .i_clr_sat(i_clr_sat), .o_mix(o_mix4), .o_valid(o_valid4),
    .o_sat(o_sat4), .o_sat_cnt(o_sat_cnt4)
  );

  typedef struct {
    int smp;
    int lo;
    int mix;
    bit sat;
  } vec_t;

  vec_t vec[12];

  task automatic chk(input string name, input logic signed [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         exp_cnt;
    int         e;
    int         stall;
    int         seen;
    logic [15:0] h_mix;
    logic        h_vld, h_sat;
    bit          pat[5];

    // Stimulus table: {sample, lo, expected mix, expected sat}
    vec[0]  = '{1000,    65536,  1000,   1'b0}; // unity gain, latency check
    vec[1]  = '{3,       32768,  2,      1'b0}; // 1.5 rounds up
    vec[2]  = '{-3,      32768,  -1,     1'b0}; // -1.5 rounds toward +inf
    vec[3]  = '{1,       32767,  0,      1'b0}; // just below half
    vec[4]  = '{-32768,  -65536, 32767,  1'b1}; // positive overflow
    vec[5]  = '{-32768,  131071, -32768, 1'b1}; // negative overflow
    vec[6]  = '{-32768,  -131072,32767,  1'b1}; // most negative LO
    vec[7]  = '{12345,   -65536, -12345, 1'b0};
    vec[8]  = '{32767,   65535,  32767,  1'b0}; // lands exactly on max
    vec[9]  = '{-32768,  65536,  -32768, 1'b0}; // lands exactly on min
    vec[10] = '{5,       -32768, -2,     1'b0}; // -2.5 rounds to -2
    vec[11] = '{32767,   65538,  32767,  1'b1}; // r=32768, just over

    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    reset_n   = 1'b0;
    ce        = 1'b1;
    i_valid   = 1'b0;
    i_sample  = '0;
    i_lo      = '0;
    i_clr_sat = 1'b0;

    #12;
    chk("rst_mix",   o_mix,     0);
    chk("rst_valid", o_valid,   0);
    chk("rst_sat",   o_sat,     0);
    chk("rst_cnt",   o_sat_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Table: one isolated sample per vector, checked 6 edges after capture
    exp_cnt = 0;
    for (int v = 0; v < 12; v++) begin
      i_sample = 16'(vec[v].smp);
      i_lo     = 18'(vec[v].lo);
      i_valid  = 1'b1;
      tick();
      i_valid = 1'b0;
      for (int k = 2; k <= 6; k++) begin
        if (v == 0) chk("lat_early_valid", o_valid, 0);
        tick();
      end
      chk("vec_valid", o_valid, 1);
      chk("vec_mix", $signed(o_mix), vec[v].mix);
      chk("vec_sat", o_sat, int'(vec[v].sat));
      if (vec[v].sat) exp_cnt++;
      chk("vec_cnt", o_sat_cnt, exp_cnt);
    end

    // Clear is ignored while ce=0, and outputs hold
    ce = 1'b0;
    i_clr_sat = 1'b1;
    tick();
    chk("ce0_clr_ignored", o_sat_cnt, exp_cnt);
    chk("ce0_valid_hold",  o_valid,   1);
    i_clr_sat = 1'b0;
    ce = 1'b1;

    // Clear on the same edge as a saturating output: clear wins
    i_sample = 16'h8000;
    i_lo     = 18'(-65536);
    i_valid  = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int k = 2; k <= 5; k++) tick();
    i_clr_sat = 1'b1;
    tick();
    i_clr_sat = 1'b0;
    chk("clrwin_sat",  o_sat,      1);
    chk("clrwin_mix",  $signed(o_mix), 32767);
    chk("clrwin_cnt",  o_sat_cnt,  0);
    chk("clrwin_cnt4", o_sat_cnt4, 0);

    // Ramp 1..20 with a 5-cycle ce stall after the 8th enabled edge
    i_lo  = 18'd65536;
    e     = 0;
    stall = 0;
    for (int cyc = 0; cyc < 40 && e < 26; cyc++) begin
      if (e == 8 && stall < 5) begin
        ce       = 1'b0;
        i_valid  = 1'b1;
        i_sample = 16'h5a5a;
        h_mix = o_mix;
        h_vld = o_valid;
        h_sat = o_sat;
        tick();
        chk("stall_mix",   o_mix,   int'(h_mix));
        chk("stall_valid", o_valid, int'(h_vld));
        chk("stall_sat",   o_sat,   int'(h_sat));
        stall++;
      end else begin
        ce = 1'b1;
        e++;
        i_valid  = (e <= 20);
        i_sample = 16'(e);
        tick();
        if (e >= 6 && e <= 25) begin
          chk("ramp_valid", o_valid, 1);
          chk("ramp_mix",   $signed(o_mix), e - 5);
        end else begin
          chk("ramp_gap", o_valid, 0);
        end
      end
    end
    ce = 1'b1;
    chk("ramp_edges", e, 26);

    // Valid gaps pass through with the same latency
    i_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 5) begin
        i_valid  = pat[k-1];
        i_sample = 16'(10 + k);
      end else begin
        i_valid = 1'b0;
      end
      tick();
      if (k >= 6) begin
        chk("gap_valid", o_valid, int'(pat[k-6]));
        if (pat[k-6]) chk("gap_mix", $signed(o_mix), k + 5);
      end
    end

    // Counter sticks at 15 in the CNT_W=4 instance
    i_valid = 1'b0;
    i_clr_sat = 1'b1;
    tick();
    i_clr_sat = 1'b0;
    chk("wrap_clr", o_sat_cnt4, 0);
    i_sample = 16'h8000;
    i_lo     = 18'(-65536);
    i_valid  = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    i_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("wrap_cnt16", o_sat_cnt,  20);
    chk("wrap_cnt4",  o_sat_cnt4, 15);
    chk("wrap_sat4",  o_sat4,     1);

    // Asynchronous reset while three samples are in flight
    i_lo = 18'd65536;
    for (int k = 0; k < 3; k++) begin
      i_valid  = 1'b1;
      i_sample = 16'(7 + k);
      tick();
    end
    i_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_mix",   o_mix,      0);
    chk("arst_valid", o_valid,    0);
    chk("arst_sat",   o_sat,      0);
    chk("arst_cnt",   o_sat_cnt,  0);
    chk("arst_cnt4",  o_sat_cnt4, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_valid) seen++;
    end
    chk("arst_no_valid", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
